// File: rtl/data_sram_like_bridge.sv
// rtl/data_sram_like_bridge.sv - single-outstanding CPU data-SRAM to sram-like bus bridge
// Decodes the store formatter's byte enables into one bus transaction and stalls until it completes.
module data_sram_like_bridge #(
    parameter bit MAP_KSEG = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_en,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic        stall_other,
    output logic [31:0] data_rdata,
    output logic        data_stall,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t      state;
    state_t      state_nx;
    logic        legal;
    logic [1:0]  dec_size;
    logic [1:0]  dec_low;
    logic [31:0] map_addr;
    logic [31:0] rdata_r;
    logic        launch;

    // The byte lanes, not the incoming address, determine the low address bits.
    always_comb begin
        legal    = 1'b1;
        dec_size = 2'd2;
        dec_low  = 2'd0;
        case (data_wen)
            4'b0000: dec_size = 2'd2;
            4'b1111: dec_size = 2'd2;
            4'b0001: dec_size = 2'd0;
            4'b0010: begin dec_size = 2'd0; dec_low = 2'd1; end
            4'b0100: begin dec_size = 2'd0; dec_low = 2'd2; end
            4'b1000: begin dec_size = 2'd0; dec_low = 2'd3; end
            4'b0011: dec_size = 2'd1;
            4'b1100: begin dec_size = 2'd1; dec_low = 2'd2; end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        map_addr = {data_addr[31:2], dec_low};
        if (MAP_KSEG && (data_addr[31:30] == 2'b10))
            map_addr[31:29] = 3'b000;
    end

    assign launch = (state == IDLE) && data_en && legal;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus_wr    <= 1'b0;
            bus_size  <= 2'd0;
            bus_addr  <= 32'd0;
            bus_wdata <= 32'd0;
        end else if (launch) begin
            bus_wr    <= (data_wen != 4'b0000);
            bus_size  <= dec_size;
            bus_addr  <= map_addr;
            bus_wdata <= data_wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            rdata_r <= 32'd0;
        else if ((state == WAIT) && bus_data_ok && !bus_wr)
            rdata_r <= bus_rdata;
    end

    // Completion releases the stall in the same cycle so the pipeline advances with the data.
    always_comb begin
        state_nx   = state;
        bus_req    = 1'b0;
        data_stall = 1'b0;
        data_rdata = rdata_r;
        case (state)
            IDLE: begin
                if (launch) begin
                    state_nx   = REQ;
                    data_stall = 1'b1;
                end
            end
            REQ: begin
                bus_req    = 1'b1;
                data_stall = 1'b1;
                if (bus_addr_ok)
                    state_nx = WAIT;
            end
            WAIT: begin
                if (bus_data_ok) begin
                    data_rdata = bus_rdata;
                    state_nx   = stall_other ? HOLD : IDLE;
                end else begin
                    data_stall = 1'b1;
                end
            end
            HOLD: begin
                if (!stall_other)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
